// File: rtl/uart_tx_sequencer.sv
// Wishbone bus master that pushes one 32-bit result through uart_interface a byte at a time:
// it configures the baud rate once, resets TX, then loads, starts, polls and clears each byte.
module uart_tx_sequencer #(
    parameter logic [31:0] BAUD_DIV    = 32'h4000_0000,
    parameter int          DONE_BIT    = 0,
    parameter int          ACK_TIMEOUT = 64,
    parameter int          POLL_GAP    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    input  logic        m_err_i
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CFG   = 4'd1,
        ST_TXRST = 4'd2,
        ST_LOAD  = 4'd3,
        ST_START = 4'd4,
        ST_POLL  = 4'd5,
        ST_WAIT  = 4'd6,
        ST_CLEAR = 4'd7,
        ST_FIN   = 4'd8,
        ST_ERR   = 4'd9
    } state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] dat;
    } bus_t;

    // Bus fields of the single transaction each bus-phase state performs.
    function automatic bus_t bus_fields(input state_t st, input logic [31:0] word, input logic [1:0] k);
        bus_t b;
        b = '0;
        case (st)
            ST_CFG:   begin b.we = 1'b1; b.sel = 4'hF; b.addr = 32'h0000_0004; b.dat = BAUD_DIV;      end
            ST_TXRST: begin b.we = 1'b1; b.sel = 4'hF; b.addr = 32'h0000_0003; b.dat = 32'h0000_0068; end
            ST_LOAD:  begin b.we = 1'b1; b.sel = 4'b0001 << k; b.addr = 32'h0000_0007; b.dat = word;   end
            ST_START: begin b.we = 1'b1; b.sel = 4'hF; b.addr = 32'h0000_0003; b.dat = 32'h0000_00E0; end
            ST_POLL:  begin b.we = 1'b0; b.sel = 4'hF; b.addr = 32'h0000_0003; b.dat = 32'h0000_0000; end
            ST_CLEAR: begin b.we = 1'b1; b.sel = 4'hF; b.addr = 32'h0000_0005; b.dat = 32'h0000_0000; end
            default:  b = '0;
        endcase
        return b;
    endfunction

    state_t             state_r, state_s;
    bus_t               bus_r, bus_s;
    logic               stb_r, stb_s;
    logic [31:0]        data_r, data_s;
    logic [1:0]         k_r, k_s;
    logic               cfg_r, cfg_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               err_r, err_s;
    logic [TMO_W-1:0]   tmo_r, tmo_s;
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic               unused_s;

    // Only the done flag of the status word is consumed.
    assign unused_s = ^m_dat_i;

    assign m_cyc_o  = stb_r;
    assign m_stb_o  = stb_r;
    assign m_we_o   = bus_r.we;
    assign m_sel_o  = bus_r.sel;
    assign m_addr_o = bus_r.addr;
    assign m_dat_o  = bus_r.dat;
    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign err_o    = err_r;

    // Next-state and next-output logic; a bus state with stb low is its idle gap cycle.
    always_comb begin
        state_s = state_r;
        bus_s   = bus_r;
        stb_s   = stb_r;
        data_s  = data_r;
        k_s     = k_r;
        cfg_s   = cfg_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        tmo_s   = tmo_r;
        gap_s   = gap_r;
        case (state_r)
            ST_IDLE: begin
                stb_s  = 1'b0;
                busy_s = 1'b0;
                if (req_i) begin
                    data_s = data_i;
                    k_s    = 2'd0;
                    busy_s = 1'b1;
                    stb_s  = 1'b1;
                    tmo_s  = '0;
                    if (cfg_r) begin
                        state_s = ST_TXRST;
                        bus_s   = bus_fields(ST_TXRST, data_i, 2'd0);
                    end else begin
                        state_s = ST_CFG;
                        bus_s   = bus_fields(ST_CFG, data_i, 2'd0);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CFG, ST_TXRST, ST_LOAD, ST_START, ST_POLL, ST_CLEAR: begin
                if (!stb_r) begin
                    stb_s = 1'b1;
                    tmo_s = '0;
                    bus_s = bus_fields(state_r, data_r, k_r);
                end else if (m_err_i) begin
                    stb_s   = 1'b0;
                    state_s = ST_ERR;
                    err_s   = 1'b1;
                end else if (m_ack_i) begin
                    stb_s = 1'b0;
                    case (state_r)
                        ST_CFG: begin
                            cfg_s   = 1'b1;
                            state_s = ST_TXRST;
                        end
                        ST_TXRST: state_s = ST_LOAD;
                        ST_LOAD:  state_s = ST_START;
                        ST_START: state_s = ST_POLL;
                        ST_POLL: begin
                            if (m_dat_i[DONE_BIT]) begin
                                state_s = ST_CLEAR;
                            end else begin
                                state_s = ST_WAIT;
                                gap_s   = '0;
                            end
                        end
                        ST_CLEAR: begin
                            if (k_r == 2'd3) begin
                                state_s = ST_FIN;
                                done_s  = 1'b1;
                            end else begin
                                k_s     = k_r + 2'd1;
                                state_s = ST_LOAD;
                            end
                        end
                        default: state_s = ST_IDLE;
                    endcase
                end else if (tmo_r == TMO_W'(ACK_TIMEOUT - 1)) begin
                    stb_s   = 1'b0;
                    state_s = ST_ERR;
                    err_s   = 1'b1;
                end else begin
                    tmo_s = tmo_r + TMO_W'(1);
                end
            end
            ST_WAIT: begin
                if (gap_r == GAP_W'(POLL_GAP - 1)) begin
                    state_s = ST_POLL;
                end else begin
                    gap_s = gap_r + GAP_W'(1);
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
            ST_ERR: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                cfg_s   = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                stb_s   = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered bus/status outputs; reset drops the bus immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            bus_r   <= '0;
            stb_r   <= 1'b0;
            data_r  <= 32'h0000_0000;
            k_r     <= 2'd0;
            cfg_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            tmo_r   <= '0;
            gap_r   <= '0;
        end else begin
            state_r <= state_s;
            bus_r   <= bus_s;
            stb_r   <= stb_s;
            data_r  <= data_s;
            k_r     <= k_s;
            cfg_r   <= cfg_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
            tmo_r   <= tmo_s;
            gap_r   <= gap_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench: stimulus queues expected bus transactions and frame-end pulses,
// monitors pop and compare them as the sequencer drives a scripted Wishbone slave.
module tb_uart_tx_sequencer;

    localparam logic [31:0] BAUD        = 32'h4000_0000;
    localparam int          ACK_TIMEOUT = 64;
    localparam int          POLL_GAP    = 8;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] dat;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] data_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] m_addr_o, m_dat_o;
    logic [31:0] m_dat_i = 32'h0;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic        m_cyc_o, m_stb_o;
    logic        m_ack_i = 1'b0;
    logic        m_err_i = 1'b0;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    txn_t exp_q[$];
    int   ev_q[$];

    int   polls_needed = 1;
    int   poll_cnt = 0;
    int   starts_seen = 0;
    bit   hang_load2 = 1'b0;
    bit   err_start0 = 1'b0;
    bit   hang_poll = 1'b0;
    bit   last_was_read = 1'b0;
    logic [31:0] uart_word = 32'h0;

    uart_tx_sequencer #(
        .BAUD_DIV(BAUD), .DONE_BIT(0), .ACK_TIMEOUT(ACK_TIMEOUT), .POLL_GAP(POLL_GAP)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .m_addr_o(m_addr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o),
        .m_sel_o(m_sel_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        txn_t t;
        t.we = 1'b1; t.sel = s; t.addr = a; t.dat = d;
        exp_q.push_back(t);
    endtask

    task automatic push_r();
        txn_t t;
        t.we = 1'b0; t.sel = 4'hF; t.addr = 32'h3; t.dat = 32'h0;
        exp_q.push_back(t);
    endtask

    task automatic push_byte(input logic [31:0] w, input int k, input int polls);
        push_w(32'h7, w, 4'b0001 << k);
        push_w(32'h3, 32'hE0, 4'hF);
        for (int p = 0; p < polls; p++) push_r();
        push_w(32'h5, 32'h0, 4'hF);
    endtask

    task automatic push_frame(input logic [31:0] w, input bit cfg, input int polls);
        if (cfg) push_w(32'h4, BAUD, 4'hF);
        push_w(32'h3, 32'h68, 4'hF);
        for (int k = 0; k < 4; k++) push_byte(w, k, polls);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_addr"}, m_addr_o, 32'h0);
        check({tag, "_dat"}, m_dat_o, 32'h0);
        check({tag, "_ctrl"}, {25'd0, m_cyc_o, m_stb_o, m_we_o, m_sel_o}, 32'h0);
        check({tag, "_status"}, {29'd0, busy_o, done_o, err_o}, 32'h0);
    endtask

    task automatic do_req(input logic [31:0] d);
        @(negedge clk_i);
        req_i = 1'b1; data_i = d;
        @(negedge clk_i);
        req_i = 1'b0; data_i = 32'h0;
        check("busy_after_accept", 32'(busy_o), 32'd1);
    endtask

    task automatic wait_frame();
        int n = 0;
        while ((busy_o || exp_q.size() != 0 || ev_q.size() != 0) && n < 4000) begin
            @(negedge clk_i);
            n++;
        end
        check("frame_completes", 32'(n < 4000), 32'd1);
        check("txn_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Scripted slave: zero-wait ack unless a fault scenario is armed.
    always @(negedge clk_i) begin
        m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = 32'h0;
        if (m_cyc_o && m_stb_o) begin
            if (hang_load2 && m_we_o && m_addr_o == 32'h7 && m_sel_o == 4'b0100) begin
            end else if (hang_poll && !m_we_o) begin
            end else if (err_start0 && m_we_o && m_addr_o == 32'h3 && m_dat_o == 32'hE0 && starts_seen == 0) begin
                m_err_i = 1'b1;
            end else begin
                m_ack_i = 1'b1;
                if (!m_we_o) m_dat_i = (poll_cnt + 1 >= polls_needed) ? 32'h0000_0001 : 32'hFFFF_FFFE;
            end
        end
    end

    // Transaction monitor: compares each completed bus cycle with the scoreboard head.
    always @(posedge clk_i) begin : txn_mon
        txn_t t;
        logic [7:0] b;
        if (!rst_i && m_cyc_o && m_stb_o && (m_ack_i || m_err_i)) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_txn: got addr %h we %b dat %h, expected none", m_addr_o, m_we_o, m_dat_o);
            end else begin
                t = exp_q.pop_front();
                check("txn_addr", m_addr_o, t.addr);
                check("txn_we_sel", {27'd0, m_we_o, m_sel_o}, {27'd0, t.we, t.sel});
                if (t.we) check("txn_wdata", m_dat_o, t.dat);
            end
            last_was_read = !m_we_o;
            if (!m_we_o && m_ack_i) poll_cnt++;
            if (m_we_o && m_addr_o == 32'h3 && m_dat_o == 32'hE0) starts_seen++;
            if (m_we_o && m_addr_o == 32'h7 && m_ack_i) begin
                poll_cnt = 0;
                case (m_sel_o)
                    4'b0001: b = m_dat_o[7:0];
                    4'b0010: b = m_dat_o[15:8];
                    4'b0100: b = m_dat_o[23:16];
                    default: b = m_dat_o[31:24];
                endcase
                uart_word = {uart_word[23:0], b};
            end
        end
    end

    // Pulse and strobe-timing monitor.
    always @(negedge clk_i) begin : evt_mon
        int e;
        static int  idle_cnt = 0;
        static int  hi_cnt = 0;
        static bit  prev_stb = 1'b0;
        static bit  hang_active = 1'b0;
        if (done_o || err_o) begin
            if (ev_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, err_o, done_o}, 32'd0);
            end else begin
                e = ev_q.pop_front();
                check("frame_end_pulse", {30'd0, err_o, done_o}, (e == 1) ? 32'd1 : 32'd2);
                check("busy_at_end", 32'(busy_o), 32'd1);
            end
        end
        if (m_stb_o && !prev_stb) begin
            if (!m_we_o && last_was_read) check("poll_spacing", 32'(idle_cnt >= POLL_GAP), 32'd1);
            hang_active = hang_load2 && m_we_o && m_addr_o == 32'h7 && m_sel_o == 4'b0100;
            hi_cnt = 0;
            idle_cnt = 0;
        end
        if (m_stb_o) hi_cnt++;
        else idle_cnt++;
        if (!m_stb_o && prev_stb && hang_active) begin
            check("timeout_stb_cycles", 32'(hi_cnt), 32'(ACK_TIMEOUT));
            hang_active = 1'b0;
        end
        prev_stb = m_stb_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i = 1'b1; req_i = 1'b0; data_i = 32'h0;
        repeat (3) @(negedge clk_i);
        check_quiet("reset");
        rst_i = 1'b0;

        // Full first frame with baud configuration.
        uart_word = 32'h0;
        push_frame(32'h6162_6364, 1'b1, 1);
        ev_q.push_back(1);
        do_req(32'h6162_6364);
        wait_frame();
        check("uart_byte_order", uart_word, 32'h6463_6261);

        // Second frame skips the baud write.
        push_frame(32'h1122_3344, 1'b0, 1);
        ev_q.push_back(1);
        do_req(32'h1122_3344);
        wait_frame();

        // Slave reports done only on the third poll of each byte.
        polls_needed = 3;
        push_frame(32'hA5C3_0F96, 1'b0, 3);
        ev_q.push_back(1);
        do_req(32'hA5C3_0F96);
        wait_frame();
        polls_needed = 1;

        // LOAD of byte 2 never acked.
        hang_load2 = 1'b1;
        push_w(32'h3, 32'h68, 4'hF);
        push_byte(32'hDEAD_BEEF, 0, 1);
        push_byte(32'hDEAD_BEEF, 1, 1);
        ev_q.push_back(2);
        do_req(32'hDEAD_BEEF);
        wait_frame();
        hang_load2 = 1'b0;

        // Bus error on START of byte 0, with a stray request while busy.
        err_start0 = 1'b1;
        starts_seen = 0;
        push_w(32'h4, BAUD, 4'hF);
        push_w(32'h3, 32'h68, 4'hF);
        push_w(32'h7, 32'h0102_0304, 4'b0001);
        push_w(32'h3, 32'hE0, 4'hF);
        ev_q.push_back(2);
        do_req(32'h0102_0304);
        req_i = 1'b1; data_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        req_i = 1'b0; data_i = 32'h0;
        wait_frame();
        err_start0 = 1'b0;
        repeat (5) @(negedge clk_i);
        check("req_during_busy_ignored", 32'(busy_o), 32'd0);

        // Reset asserted while a status poll is outstanding.
        hang_poll = 1'b1;
        push_w(32'h4, BAUD, 4'hF);
        push_w(32'h3, 32'h68, 4'hF);
        push_w(32'h7, 32'h0BAD_F00D, 4'b0001);
        push_w(32'h3, 32'hE0, 4'hF);
        do_req(32'h0BAD_F00D);
        n = 0;
        while (!(m_stb_o && !m_we_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("poll_reached", 32'(n < 200), 32'd1);
        rst_i = 1'b1;
        #1;
        check_quiet("midpoll_reset");
        check("queue_before_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        ev_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        hang_poll = 1'b0;

        // After reset the baud divisor is written again.
        push_frame(32'h55AA_33CC, 1'b1, 1);
        ev_q.push_back(1);
        do_req(32'h55AA_33CC);
        wait_frame();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
